// File: rtl/mem_stage_nlane_if.sv
// MEM-stage bundle: EX/MEM inputs and MEM/WB outputs for LANES issue slots.
// Lane k of every bus occupies [k*W +: W] for that bus's per-lane width W.
interface mem_stage_nlane_if #(
  parameter int D_WIDTH  = 32,
  parameter int LANES    = 2,
  parameter int WA_WIDTH = 4
);
  logic                        i_stall;
  logic                        i_flush;
  logic [LANES-1:0]            i_valid;
  logic [LANES-1:0]            i_PCSrc;
  logic [LANES-1:0]            i_RegWrite;
  logic [LANES-1:0]            i_MemtoReg;
  logic [LANES-1:0]            i_MemWrite;
  logic [LANES*D_WIDTH-1:0]    i_ALUResult;
  logic [LANES*D_WIDTH-1:0]    i_WriteData;
  logic [LANES*WA_WIDTH-1:0]   i_WA;

  logic [LANES-1:0]            o_valid;
  logic [LANES-1:0]            o_PCSrc;
  logic [LANES-1:0]            o_RegWrite;
  logic [LANES-1:0]            o_MemtoReg;
  logic [LANES*D_WIDTH-1:0]    o_RD;
  logic [LANES*D_WIDTH-1:0]    o_ALUOut;
  logic [LANES*D_WIDTH-1:0]    o_Result;
  logic [LANES*WA_WIDTH-1:0]   o_WA;
  logic [LANES-1:0]            o_misalign;

  modport master (
    output i_stall, i_flush, i_valid, i_PCSrc, i_RegWrite, i_MemtoReg, i_MemWrite,
           i_ALUResult, i_WriteData, i_WA,
    input  o_valid, o_PCSrc, o_RegWrite, o_MemtoReg, o_RD, o_ALUOut, o_Result,
           o_WA, o_misalign
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_PCSrc, i_RegWrite, i_MemtoReg, i_MemWrite,
           i_ALUResult, i_WriteData, i_WA,
    output o_valid, o_PCSrc, o_RegWrite, o_MemtoReg, o_RD, o_ALUOut, o_Result,
           o_WA, o_misalign
  );
endinterface

// File: rtl/mem_stage_nlane.sv
// N-lane MEM stage: multi-write-port data memory with older-lane store-to-load
// forwarding, misalignment trapping and a 1-cycle MEM/WB register (stall holds, flush kills).
module mem_stage_nlane #(
  parameter int D_WIDTH  = 32,
  parameter int LANES    = 2,
  parameter int WA_WIDTH = 4,
  parameter int DEPTH    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_stage_nlane_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [D_WIDTH-1:0]        mem_q [DEPTH];
  logic [D_WIDTH-1:0]        mem_d [DEPTH];
  logic [AW-1:0]             idx [LANES];
  logic [LANES-1:0]          mis, fwd_src, st;
  logic [LANES*D_WIDTH-1:0]  rd;

  logic [LANES-1:0]          valid_q, valid_d, pcsrc_q, pcsrc_d, regwrite_q, regwrite_d;
  logic [LANES-1:0]          memtoreg_q, memtoreg_d, misalign_q, misalign_d;
  logic [LANES*D_WIDTH-1:0]  rd_q, rd_d, aluout_q, aluout_d, result_q, result_d;
  logic [LANES*WA_WIDTH-1:0] wa_q, wa_d;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      idx[k]     = bus.i_ALUResult[k*D_WIDTH+2 +: AW];
      mis[k]     = bus.i_valid[k] & (bus.i_MemWrite[k] | bus.i_MemtoReg[k]) &
                   (bus.i_ALUResult[k*D_WIDTH +: 2] != 2'b00);
      fwd_src[k] = bus.i_valid[k] & bus.i_MemWrite[k] & ~mis[k];
      st[k]      = fwd_src[k] & ~bus.i_stall & ~bus.i_flush;
    end
  end

  // Ascending scan over older lanes leaves the youngest matching store in place.
  always_comb begin
    rd = '0;
    for (int k = 0; k < LANES; k++) begin
      rd[k*D_WIDTH +: D_WIDTH] = mem_q[idx[k]];
      for (int j = 0; j < LANES; j++) begin
        if (j < k && fwd_src[j] && idx[j] == idx[k])
          rd[k*D_WIDTH +: D_WIDTH] = bus.i_WriteData[j*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < LANES; k++) begin
      if (st[k]) mem_d[idx[k]] = bus.i_WriteData[k*D_WIDTH +: D_WIDTH];
    end
  end

  always_comb begin
    valid_d    = valid_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    misalign_d = misalign_q;
    rd_d       = rd_q;
    aluout_d   = aluout_q;
    result_d   = result_q;
    wa_d       = wa_q;
    if (bus.i_flush) begin
      valid_d    = '0;
      misalign_d = '0;
    end else if (!bus.i_stall) begin
      valid_d    = bus.i_valid;
      pcsrc_d    = bus.i_PCSrc;
      regwrite_d = bus.i_valid & bus.i_RegWrite & ~mis;
      memtoreg_d = bus.i_MemtoReg;
      misalign_d = mis;
      rd_d       = rd;
      aluout_d   = bus.i_ALUResult;
      wa_d       = bus.i_WA;
      for (int k = 0; k < LANES; k++) begin
        result_d[k*D_WIDTH +: D_WIDTH] = bus.i_MemtoReg[k] ? rd[k*D_WIDTH +: D_WIDTH]
                                                            : bus.i_ALUResult[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q    <= '0;
      pcsrc_q    <= '0;
      regwrite_q <= '0;
      memtoreg_q <= '0;
      misalign_q <= '0;
      rd_q       <= '0;
      aluout_q   <= '0;
      result_q   <= '0;
      wa_q       <= '0;
    end else begin
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      misalign_q <= misalign_d;
      rd_q       <= rd_d;
      aluout_q   <= aluout_d;
      result_q   <= result_d;
      wa_q       <= wa_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_PCSrc    = pcsrc_q;
  assign bus.o_RegWrite = regwrite_q;
  assign bus.o_MemtoReg = memtoreg_q;
  assign bus.o_misalign = misalign_q;
  assign bus.o_RD       = rd_q;
  assign bus.o_ALUOut   = aluout_q;
  assign bus.o_Result   = result_q;
  assign bus.o_WA       = wa_q;
endmodule

// File: tb/tb_mem_stage_nlane.sv
// Directed bench for the 2-lane MEM stage: stimulus pushes hand-computed
// expectations into a queue, a monitor pops one per clock and compares.
module tb_mem_stage_nlane;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_nlane_if #(.D_WIDTH(32), .LANES(2), .WA_WIDTH(4)) bus ();

  mem_stage_nlane #(.D_WIDTH(32), .LANES(2), .WA_WIDTH(4), .DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        full;
    logic        chk_rw;
    logic [1:0]  valid, rw, mis, rdc, resc;
    logic [63:0] rd, res;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(logic [1:0] v, logic [1:0] rw, logic [1:0] mis,
                              logic [1:0] rdc, logic [1:0] resc,
                              logic [63:0] rd, logic [63:0] res,
                              logic chk_rw = 1'b1, logic full = 1'b0);
    exp_t e;
    e.full = full; e.chk_rw = chk_rw; e.valid = v; e.rw = rw; e.mis = mis;
    e.rdc = rdc; e.resc = resc; e.rd = rd; e.res = res;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue what the next rising edge must produce.
  task automatic cyc(logic rstn, logic stall, logic flush, logic [1:0] v, logic [1:0] rw,
                     logic [1:0] m2r, logic [1:0] mw, logic [63:0] alu, logic [63:0] wd,
                     exp_t e);
    @(negedge clk);
    rst_n           = rstn;
    bus.i_stall     = stall;
    bus.i_flush     = flush;
    bus.i_valid     = v;
    bus.i_PCSrc     = v;
    bus.i_RegWrite  = rw;
    bus.i_MemtoReg  = m2r;
    bus.i_MemWrite  = mw;
    bus.i_ALUResult = alu;
    bus.i_WriteData = wd;
    bus.i_WA        = 8'h53;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o_valid", 64'(bus.o_valid), 64'(e.valid));
        chk("o_misalign", 64'(bus.o_misalign), 64'(e.mis));
        if (e.chk_rw) chk("o_RegWrite", 64'(bus.o_RegWrite), 64'(e.rw));
        for (int k = 0; k < 2; k++) begin
          if (e.rdc[k])
            chk($sformatf("o_RD%0d", k), 64'(bus.o_RD[k*32 +: 32]), 64'(e.rd[k*32 +: 32]));
          if (e.resc[k])
            chk($sformatf("o_Result%0d", k), 64'(bus.o_Result[k*32 +: 32]), 64'(e.res[k*32 +: 32]));
        end
        if (e.full) begin
          chk("rst o_PCSrc", 64'(bus.o_PCSrc), 64'd0);
          chk("rst o_MemtoReg", 64'(bus.o_MemtoReg), 64'd0);
          chk("rst o_WA", 64'(bus.o_WA), 64'd0);
          chk("rst o_ALUOut", bus.o_ALUOut, 64'd0);
        end
      end
    end
  end

  initial begin : stim
    int guard;
    bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_valid = '0; bus.i_PCSrc = '0;
    bus.i_RegWrite = '0; bus.i_MemtoReg = '0; bus.i_MemWrite = '0;
    bus.i_ALUResult = '0; bus.i_WriteData = '0; bus.i_WA = '0;

    // reset with a live store on the inputs: outputs zero, store dropped
    repeat (2)
      cyc(0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b01, {32'h0, 32'h10}, {32'h0, 32'h99},
          mk(2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 64'h0, 64'h0, 1'b1, 1'b1));
    cyc(1, 0, 0, 2'b01, 2'b01, 2'b01, 2'b00, {32'h0, 32'h10}, 64'h0,
        mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 64'h0, 64'h0));
    // store then load on the other lane
    cyc(1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, {32'h0, 32'h20}, {32'h0, 32'hDEADBEEF},
        mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0));
    cyc(1, 0, 0, 2'b10, 2'b10, 2'b10, 2'b00, {32'h20, 32'h0}, 64'h0,
        mk(2'b10, 2'b10, 2'b00, 2'b10, 2'b10, {32'hDEADBEEF, 32'h0}, {32'hDEADBEEF, 32'h0}));
    // forwarding lane0 -> lane1
    cyc(1, 0, 0, 2'b11, 2'b10, 2'b10, 2'b01, {32'h40, 32'h40}, {32'h0, 32'h1234},
        mk(2'b11, 2'b10, 2'b00, 2'b10, 2'b10, {32'h1234, 32'h0}, {32'h1234, 32'h0}));
    // younger store never reaches older load
    cyc(1, 0, 0, 2'b11, 2'b01, 2'b01, 2'b10, {32'h44, 32'h44}, {32'h5678, 32'h0},
        mk(2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 64'h0, 64'h0));
    // same-index store conflict
    cyc(1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b11, {32'h80, 32'h80}, {32'hBBBB, 32'hAAAA},
        mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0));
    cyc(1, 0, 0, 2'b11, 2'b11, 2'b11, 2'b00, {32'h44, 32'h80}, 64'h0,
        mk(2'b11, 2'b11, 2'b00, 2'b11, 2'b11, {32'h5678, 32'hBBBB}, {32'h5678, 32'hBBBB}));
    // misaligned store on lane0, plain ALU op on lane1
    cyc(1, 0, 0, 2'b11, 2'b11, 2'b00, 2'b01, {32'h7, 32'h22}, {32'h0, 32'hCAFE},
        mk(2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 64'h0, {32'h7, 32'h0}));
    cyc(1, 0, 0, 2'b11, 2'b11, 2'b11, 2'b00, {32'h41, 32'h20}, 64'h0,
        mk(2'b11, 2'b01, 2'b10, 2'b01, 2'b01, {32'h0, 32'hDEADBEEF}, {32'h0, 32'hDEADBEEF}));
    // stall: outputs hold the previous cycle, store suppressed
    cyc(1, 1, 0, 2'b01, 2'b00, 2'b00, 2'b01, {32'h0, 32'h30}, {32'h0, 32'h5},
        mk(2'b11, 2'b01, 2'b10, 2'b01, 2'b01, {32'h0, 32'hDEADBEEF}, {32'h0, 32'hDEADBEEF}));
    cyc(1, 0, 0, 2'b01, 2'b01, 2'b01, 2'b00, {32'h0, 32'h30}, 64'h0,
        mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 64'h0, 64'h0));
    // flush kills a load and a store
    cyc(1, 0, 1, 2'b11, 2'b01, 2'b01, 2'b10, {32'h20, 32'h20}, {32'h77, 32'h0},
        mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0));
    cyc(1, 0, 0, 2'b11, 2'b01, 2'b01, 2'b10, {32'h21, 32'h20}, {32'h99, 32'h0},
        mk(2'b11, 2'b01, 2'b10, 2'b01, 2'b01, {32'h0, 32'hDEADBEEF}, {32'h0, 32'hDEADBEEF}));
    // flush beats stall
    cyc(1, 1, 1, 2'b01, 2'b01, 2'b01, 2'b00, {32'h0, 32'h20}, 64'h0,
        mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 1'b0));
    // address wrap modulo DEPTH*4, forwarded across the wrap
    cyc(1, 0, 0, 2'b11, 2'b10, 2'b10, 2'b01, {32'h8, 32'h408}, {32'h0, 32'h3C3C},
        mk(2'b11, 2'b10, 2'b00, 2'b10, 2'b10, {32'h3C3C, 32'h0}, {32'h3C3C, 32'h0}));
    // invalid lane1 with RegWrite set must not write back
    cyc(1, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, {32'h0, 32'h8}, 64'h0,
        mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, {32'h0, 32'h3C3C}, {32'h0, 32'h3C3C}));
    @(negedge clk);
    bus.i_valid = '0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_nlane.md
Name: mem_stage_nlane

Overview:
- Parametrised successor to the dual-issue MEM stage.
- Generalised to LANES issue slots. Contains an internal multi-write-port data memory.
- Adds same-cycle store-to-load forwarding between lanes, misalignment trapping, and a registered MEM/WB boundary with stall and flush.
- Sits between the EX/MEM register and the writeback stage of the superscalar pipeline.

Parameters:
- D_WIDTH, 32, data and address width.
- LANES, 2, issue lanes. Lane 0 is oldest in program order.
- WA_WIDTH, 4, register write-address width.
- DEPTH, 256, data memory words (power of 2). AW = log2(DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_stall  in  1  hold MEM/WB register and suppress memory writes
- i_flush  in  1  kill current inputs
- i_valid  in  LANES  lane valid
- i_PCSrc  in  LANES  branch-taken flag, passed through
- i_RegWrite  in  LANES  register write enable
- i_MemtoReg  in  LANES  load select
- i_MemWrite  in  LANES  store enable
- i_ALUResult  in  LANES*D_WIDTH  address/ALU result. Lane k occupies [k*D_WIDTH +: D_WIDTH]; all buses use this packing.
- i_WriteData  in  LANES*D_WIDTH  store data
- i_WA  in  LANES*WA_WIDTH  destination register
- o_valid  out  LANES  registered lane valid
- o_PCSrc, o_RegWrite, o_MemtoReg  out  LANES each  registered controls
- o_RD  out  LANES*D_WIDTH  registered load data
- o_ALUOut  out  LANES*D_WIDTH  registered ALU result
- o_Result  out  LANES*D_WIDTH  registered writeback value: MemtoReg ? RD : ALUOut
- o_WA  out  LANES*WA_WIDTH  registered write address
- o_misalign  out  LANES  registered misaligned-access flag

Behaviour:
- Reset (rst_n=0 at posedge): every output register cleared to 0. All DEPTH memory words cleared to 0. No write takes place that cycle.
- Word addressing: index = ALUResult[AW+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Misaligned condition: misaligned_k = valid_k & (MemWrite_k | MemtoReg_k) & (ALUResult_k[1:0] != 0).
  - The store is suppressed.
  - Registered o_RegWrite_k is forced 0.
  - o_misalign_k = 1.
- Effective store: st_k = valid_k & MemWrite_k & ~misaligned_k & ~i_stall & ~i_flush.
- Memory write timing: effective stores are written at posedge.
- Same-index store conflict: the highest-numbered (youngest) lane wins.
- Load data, computed combinationally from the current memory array plus forwarding:
  - If some lane j<k has valid & MemWrite & ~misaligned to the same index, lane k gets the youngest such j's WriteData.
  - Otherwise lane k gets mem[index].
  - Lanes j>=k are never forwarded to lane k.
  - A load never observes its own lane's store.
- Latency: exactly 1 cycle from inputs to MEM/WB outputs.
- i_flush=1 (priority over stall): o_valid <= 0 and o_misalign <= 0. Other registered fields are don't-care; no stores occur.
- i_stall=1 (no flush): all output registers hold and no stores occur. Upstream holds its inputs.
- Normal cycle: all outputs load from the current inputs. For an invalid lane, o_valid=0 and o_RegWrite=0.
- Pass-through fields o_PCSrc, o_ALUOut and o_WA are registered unmodified.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then load lane0 addr 0x10 -> o_RD0=0, all outputs 0 during reset.
- Store then load: lane0 stores 0xDEADBEEF @0x20. Next cycle lane1 loads @0x20 -> o_RD1=o_Result1=0xDEADBEEF one cycle later.
- Intra-cycle forwarding: same cycle, lane0 stores 0x1234 @0x40 and lane1 loads @0x40 -> o_RD1=0x1234. Reverse lanes (lane1 store, lane0 load) -> o_RD0 = old mem value 0.
- Write conflict: both lanes store @0x80 (0xAAAA lane0, 0xBBBB lane1). A later load @0x80 -> 0xBBBB.
- Misalign: lane0 store @0x22 -> o_misalign0=1, o_RegWrite0=0. A later load @0x20 returns the prior value unchanged.
- Stall/flush:
  - Stall with lane0 storing 0x5 @0x30 -> outputs hold and mem[0x30] is unchanged.
  - Flush with a valid load -> o_valid=00 next cycle.
  - Flush and stall together -> flush wins.
